// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer around one full-adder cell
// Operands stream LSB-first through a single registered-carry adder; result reassembled in a shift register.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic             carry_msb;
   logic [CW-1:0]    bit_cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;
   logic             msb_in_bit;

   assign fa_s       = op_a[0] ^ op_b[0] ^ carry;
   assign fa_c       = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
   assign last_bit   = (bit_cnt == CW'(WIDTH - 1));
   // carry leaving bit WIDTH-2 is the carry entering the MSB
   assign msb_in_bit = (bit_cnt == CW'(WIDTH - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_bit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         res_sr    <= '0;
         carry     <= 1'b0;
         carry_msb <= 1'b0;
         bit_cnt   <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_a    <= a;
                  op_b    <= sub ? ~b : b;
                  carry   <= sub ? 1'b1 : cin;
                  res_sr  <= '0;
                  bit_cnt <= '0;
               end
            end
            S_RUN: begin
               op_a   <= op_a >> 1;
               op_b   <= op_b >> 1;
               carry  <= fa_c;
               res_sr <= {fa_s, res_sr[WIDTH-1:1]};
               if (msb_in_bit) carry_msb <= fa_c;
               if (last_bit) begin
                  sum  <= {fa_s, res_sr[WIDTH-1:1]};
                  cout <= fa_c;
                  ovf  <= carry_msb ^ fa_c;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
